// File: rtl/mc6800_peripheral_responder.sv
// mc6800_peripheral_responder
// Peripheral end of the emulated 6800 synchronous bus. A selected cycle
// asserts MB_VPA, waits for MB_VMA and then moves data aligned to E.
// Also hosts a 16-bit down-counting interval timer ticked by E rises,
// with a level interrupt on underflow.
module mc6800_peripheral_responder #(
  parameter int               TIMER_WIDTH = 16,
  parameter logic [15:0]      LATCH_RESET = 16'hFFFF,
  parameter int               VMA_TIMEOUT = 24
) (
  input  logic       MB_CLK,
  input  logic       RESET,
  input  logic       MB_E_CLK,
  input  logic       CPU_AS,
  input  logic       CPU_RW,
  input  logic       SEL,
  input  logic [1:0] ADDR,
  input  logic [7:0] DATA_IN,
  input  logic       MB_VMA,
  output logic       MB_VPA,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       INT_N
);

  localparam int TO_W = $clog2(VMA_TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VPA    = 3'd1;
  localparam logic [2:0] ST_WAIT_E = 3'd2;
  localparam logic [2:0] ST_E_HIGH = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]             state;
  logic [TO_W-1:0]        timeout_cnt;
  logic                   e_d;
  logic                   e_rise;
  logic                   e_fall;
  logic [TIMER_WIDTH-1:0] latch_q;
  logic [TIMER_WIDTH-1:0] counter_q;
  logic                   start_q;
  logic                   oneshot_q;
  logic                   irqen_q;
  logic                   stat_q;
  logic [7:0]             reg_rdata;
  logic                   wr_commit;
  logic                   rd_commit;
  logic                   stat_clr;
  logic                   underflow;
  logic                   load_hi;
  logic                   force_load;

  // Delayed copy of E used to find its edges in the MB_CLK domain
  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      e_d <= 1'b0;
    end else begin
      e_d <= MB_E_CLK;
    end
  end

  assign e_rise = MB_E_CLK & ~e_d;
  assign e_fall = ~MB_E_CLK & e_d;

  // Register accesses take effect on the fall that ends E high, unless the strobe went away
  assign wr_commit  = (state == ST_E_HIGH) && e_fall && !CPU_AS && !CPU_RW;
  assign rd_commit  = (state == ST_E_HIGH) && e_fall && !CPU_AS && CPU_RW;
  assign stat_clr   = rd_commit && (ADDR == 2'd3);
  assign underflow  = start_q && e_rise && (counter_q == '0);
  assign load_hi    = wr_commit && (ADDR == 2'd1) && !start_q;
  assign force_load = wr_commit && (ADDR == 2'd2) && DATA_IN[4];

  // Read data selection for the four registers
  always_comb begin
    reg_rdata = 8'h00;
    case (ADDR)
      2'd0: reg_rdata = counter_q[7:0];
      2'd1: reg_rdata = counter_q[15:8];
      2'd2: reg_rdata = {5'b00000, irqen_q, oneshot_q, start_q};
      2'd3: reg_rdata = {stat_q & irqen_q, 6'b000000, stat_q};
      default: reg_rdata = 8'h00;
    endcase
  end

  // Bus handshake sequencer; a negated strobe always returns to idle first
  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      timeout_cnt <= '0;
      MB_VPA      <= 1'b1;
      DATA_OUT    <= 8'h00;
      DATA_OE     <= 1'b0;
    end else if (CPU_AS) begin
      state   <= ST_IDLE;
      MB_VPA  <= 1'b1;
      DATA_OE <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (SEL) begin
            state       <= ST_VPA;
            MB_VPA      <= 1'b0;
            timeout_cnt <= '0;
          end
        end
        ST_VPA: begin
          if (!MB_VMA) begin
            state <= ST_WAIT_E;
          end else if (timeout_cnt == TO_W'(VMA_TIMEOUT - 1)) begin
            state <= ST_DONE;
          end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
          end
        end
        ST_WAIT_E: begin
          if (e_rise) begin
            state <= ST_E_HIGH;
            if (CPU_RW) begin
              DATA_OUT <= reg_rdata;
              DATA_OE  <= 1'b1;
            end
          end
        end
        ST_E_HIGH: begin
          if (e_fall) begin
            state   <= ST_DONE;
            DATA_OE <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state  <= ST_IDLE;
          MB_VPA <= 1'b1;
        end
      endcase
    end
  end

  // Timer latch, written a byte at a time
  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      latch_q <= LATCH_RESET;
    end else if (wr_commit && (ADDR == 2'd0)) begin
      latch_q[7:0] <= DATA_IN;
    end else if (wr_commit && (ADDR == 2'd1)) begin
      latch_q[15:8] <= DATA_IN;
    end
  end

  // Down-counter: explicit loads beat the E-driven decrement and reload
  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      counter_q <= LATCH_RESET;
    end else if (load_hi) begin
      counter_q <= {DATA_IN, latch_q[7:0]};
    end else if (force_load) begin
      counter_q <= latch_q;
    end else if (underflow) begin
      counter_q <= latch_q;
    end else if (start_q && e_rise) begin
      counter_q <= counter_q - TIMER_WIDTH'(1);
    end
  end

  // Control bits; a one-shot timer stops itself at underflow
  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      start_q   <= 1'b0;
      oneshot_q <= 1'b0;
      irqen_q   <= 1'b0;
    end else if (wr_commit && (ADDR == 2'd2)) begin
      start_q   <= DATA_IN[0];
      oneshot_q <= DATA_IN[1];
      irqen_q   <= DATA_IN[2];
    end else if (underflow && oneshot_q) begin
      start_q <= 1'b0;
    end
  end

  // Underflow flag; setting outranks the read-to-clear
  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      stat_q <= 1'b0;
    end else if (underflow) begin
      stat_q <= 1'b1;
    end else if (stat_clr) begin
      stat_q <= 1'b0;
    end
  end

  // Registered active-low interrupt level
  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      INT_N <= 1'b1;
    end else begin
      INT_N <= ~(stat_q & irqen_q);
    end
  end

endmodule

// File: tb/tb_mc6800_peripheral_responder.sv
// tb_mc6800_peripheral_responder
// Directed bench: a table of register bus cycles plus hand-written
// sequences for timer underflow, VMA timeout, strobe abort and reset.
module tb_mc6800_peripheral_responder;

  logic       MB_CLK;
  logic       RESET;
  logic       MB_E_CLK;
  logic       CPU_AS;
  logic       CPU_RW;
  logic       SEL;
  logic [1:0] ADDR;
  logic [7:0] DATA_IN;
  logic       MB_VMA;
  logic       MB_VPA;
  logic [7:0] DATA_OUT;
  logic       DATA_OE;
  logic       INT_N;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  mc6800_peripheral_responder dut (
    .MB_CLK   (MB_CLK),
    .RESET    (RESET),
    .MB_E_CLK (MB_E_CLK),
    .CPU_AS   (CPU_AS),
    .CPU_RW   (CPU_RW),
    .SEL      (SEL),
    .ADDR     (ADDR),
    .DATA_IN  (DATA_IN),
    .MB_VMA   (MB_VMA),
    .MB_VPA   (MB_VPA),
    .DATA_OUT (DATA_OUT),
    .DATA_OE  (DATA_OE),
    .INT_N    (INT_N)
  );

  // 10 ns motherboard clock
  initial begin
    MB_CLK = 1'b0;
    forever #5 MB_CLK = ~MB_CLK;
  end

  // E: period 10 MB_CLK, high for 4, changing on the falling MB_CLK edge
  initial begin
    int phase;
    phase = 0;
    MB_E_CLK = 1'b0;
    forever begin
      @(negedge MB_CLK);
      phase = (phase == 9) ? 0 : phase + 1;
      MB_E_CLK = (phase < 4);
    end
  end

  // Overall time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MB_CLK);
    #1;
  endtask

  // Full 6800 bus cycle; returns read data captured at the E rise
  task automatic applyStimulus(input logic rw, input logic [1:0] a, input logic [7:0] wd,
                               output logic [7:0] rd);
    logic pe;
    logic seen_rise;
    logic done;
    rd = 8'h00;
    CPU_AS = 1'b0; SEL = 1'b1; CPU_RW = rw; ADDR = a; DATA_IN = wd; MB_VMA = 1'b1;
    tick();
    checkOutput("vpa_assert", 16'(MB_VPA), 16'd0);
    MB_VMA = 1'b0;
    tick();
    pe = MB_E_CLK;
    seen_rise = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      if (MB_E_CLK && !pe && !seen_rise) begin
        seen_rise = 1'b1;
        if (rw) begin
          rd = DATA_OUT;
          checkOutput("oe_at_rise", 16'(DATA_OE), 16'd1);
        end
      end else if (!MB_E_CLK && pe && seen_rise) begin
        done = 1'b1;
        checkOutput("oe_after_fall", 16'(DATA_OE), 16'd0);
      end
      pe = MB_E_CLK;
    end
    checkOutput("bus_cycle_done", 16'(done), 16'd1);
    CPU_AS = 1'b1; SEL = 1'b0; MB_VMA = 1'b1;
    tick();
    checkOutput("vpa_release", 16'(MB_VPA), 16'd1);
  endtask

  // Waits for n rising E edges as seen by the DUT, bounded
  task automatic waitRises(input int n);
    logic pe;
    int cnt;
    pe = MB_E_CLK;
    cnt = 0;
    for (int k = 0; k < 200 && cnt < n; k++) begin
      tick();
      if (MB_E_CLK && !pe) cnt++;
      pe = MB_E_CLK;
    end
    checkOutput("rise_wait", 16'(cnt), 16'(n));
  endtask

  initial begin
    logic [7:0] rd;
    logic       got;

    vecs[0]  = '{1'b0, 2'd0, 8'h05, 8'h00};
    vecs[1]  = '{1'b0, 2'd1, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 2'd0, 8'h00, 8'h05};
    vecs[3]  = '{1'b1, 2'd1, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 2'd2, 8'h06, 8'h00};
    vecs[5]  = '{1'b1, 2'd2, 8'h00, 8'h06};
    vecs[6]  = '{1'b0, 2'd0, 8'h34, 8'h00};
    vecs[7]  = '{1'b0, 2'd1, 8'h12, 8'h00};
    vecs[8]  = '{1'b1, 2'd0, 8'h00, 8'h34};
    vecs[9]  = '{1'b1, 2'd1, 8'h00, 8'h12};
    vecs[10] = '{1'b0, 2'd0, 8'h56, 8'h00};
    vecs[11] = '{1'b1, 2'd0, 8'h00, 8'h34};
    vecs[12] = '{1'b0, 2'd2, 8'hF8, 8'h00};
    vecs[13] = '{1'b1, 2'd0, 8'h00, 8'h56};
    vecs[14] = '{1'b1, 2'd2, 8'h00, 8'h00};
    vecs[15] = '{1'b1, 2'd3, 8'h00, 8'h00};

    RESET = 1'b1; CPU_AS = 1'b1; SEL = 1'b0; CPU_RW = 1'b1;
    ADDR = 2'd0; DATA_IN = 8'h00; MB_VMA = 1'b1;
    repeat (3) tick();
    checkOutput("rst_vpa", 16'(MB_VPA), 16'd1);
    checkOutput("rst_oe", 16'(DATA_OE), 16'd0);
    checkOutput("rst_int", 16'(INT_N), 16'd1);
    checkOutput("rst_dout", 16'(DATA_OUT), 16'd0);
    RESET = 1'b0;
    tick();

    applyStimulus(1'b1, 2'd0, 8'h00, rd);
    checkOutput("rst_cnt_lo", 16'(rd), 16'hFF);
    applyStimulus(1'b1, 2'd1, 8'h00, rd);
    checkOutput("rst_cnt_hi", 16'(rd), 16'hFF);

    // Register table
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].data, rd);
      if (vecs[i].rw) checkOutput($sformatf("vec%0d", i), 16'(rd), 16'(vecs[i].exp_data));
    end

    // One-shot: counter 5 underflows at the 6th rise
    applyStimulus(1'b0, 2'd0, 8'h05, rd);
    applyStimulus(1'b0, 2'd1, 8'h00, rd);
    applyStimulus(1'b0, 2'd2, 8'h07, rd);
    waitRises(5);
    checkOutput("os_int_before", 16'(INT_N), 16'd1);
    waitRises(1);
    tick();
    checkOutput("os_int_after", 16'(INT_N), 16'd0);
    applyStimulus(1'b1, 2'd2, 8'h00, rd);
    checkOutput("os_ctrl", 16'(rd), 16'h06);
    applyStimulus(1'b1, 2'd0, 8'h00, rd);
    checkOutput("os_cnt_lo", 16'(rd), 16'h05);
    applyStimulus(1'b1, 2'd1, 8'h00, rd);
    checkOutput("os_cnt_hi", 16'(rd), 16'h00);
    applyStimulus(1'b1, 2'd3, 8'h00, rd);
    checkOutput("os_stat", 16'(rd), 16'h81);
    checkOutput("os_int_cleared", 16'(INT_N), 16'd1);
    applyStimulus(1'b1, 2'd3, 8'h00, rd);
    checkOutput("os_stat_again", 16'(rd), 16'h00);

    // Continuous: latch 2, underflow every third rise, START kept
    applyStimulus(1'b0, 2'd0, 8'h02, rd);
    applyStimulus(1'b0, 2'd1, 8'h00, rd);
    applyStimulus(1'b0, 2'd2, 8'h05, rd);
    waitRises(2);
    tick();
    checkOutput("ct_int_before", 16'(INT_N), 16'd1);
    waitRises(1);
    tick();
    checkOutput("ct_int_after", 16'(INT_N), 16'd0);
    applyStimulus(1'b1, 2'd2, 8'h00, rd);
    checkOutput("ct_ctrl", 16'(rd), 16'h05);
    applyStimulus(1'b1, 2'd3, 8'h00, rd);
    checkOutput("ct_stat", 16'(rd), 16'h81);
    checkOutput("ct_int_cleared", 16'(INT_N), 16'd1);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      if (!INT_N) got = 1'b1;
    end
    checkOutput("ct_next_underflow", 16'(got), 16'd1);

    // Reset during E high of a STAT read with an interrupt pending
    checkOutput("rr_int_pending", 16'(INT_N), 16'd0);
    CPU_AS = 1'b0; SEL = 1'b1; CPU_RW = 1'b1; ADDR = 2'd3; MB_VMA = 1'b1;
    tick();
    MB_VMA = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (DATA_OE) got = 1'b1;
    end
    checkOutput("rr_reached_e_high", 16'(got), 16'd1);
    #2 RESET = 1'b1;
    #1;
    checkOutput("rr_vpa", 16'(MB_VPA), 16'd1);
    checkOutput("rr_oe", 16'(DATA_OE), 16'd0);
    checkOutput("rr_int", 16'(INT_N), 16'd1);
    CPU_AS = 1'b1; SEL = 1'b0; MB_VMA = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    applyStimulus(1'b1, 2'd0, 8'h00, rd);
    checkOutput("rr_cnt_lo", 16'(rd), 16'hFF);
    applyStimulus(1'b1, 2'd1, 8'h00, rd);
    checkOutput("rr_cnt_hi", 16'(rd), 16'hFF);
    applyStimulus(1'b1, 2'd2, 8'h00, rd);
    checkOutput("rr_ctrl", 16'(rd), 16'h00);
    applyStimulus(1'b1, 2'd3, 8'h00, rd);
    checkOutput("rr_stat", 16'(rd), 16'h00);

    // VMA never asserted: cycle times out, late VMA and E do nothing
    CPU_AS = 1'b0; SEL = 1'b1; CPU_RW = 1'b0; ADDR = 2'd0; DATA_IN = 8'hAA; MB_VMA = 1'b1;
    tick();
    checkOutput("to_vpa_low", 16'(MB_VPA), 16'd0);
    repeat (30) tick();
    checkOutput("to_vpa_held", 16'(MB_VPA), 16'd0);
    MB_VMA = 1'b0;
    repeat (25) tick();
    checkOutput("to_vpa_done", 16'(MB_VPA), 16'd0);
    CPU_AS = 1'b1; SEL = 1'b0; MB_VMA = 1'b1;
    tick();
    checkOutput("to_vpa_release", 16'(MB_VPA), 16'd1);
    applyStimulus(1'b0, 2'd2, 8'h10, rd);
    applyStimulus(1'b1, 2'd0, 8'h00, rd);
    checkOutput("to_latch_lo", 16'(rd), 16'hFF);

    // Strobe negated in WAIT_E during a write to the high byte
    CPU_AS = 1'b0; SEL = 1'b1; CPU_RW = 1'b0; ADDR = 2'd1; DATA_IN = 8'h12; MB_VMA = 1'b1;
    tick();
    MB_VMA = 1'b0;
    tick();
    CPU_AS = 1'b1; SEL = 1'b0; MB_VMA = 1'b1;
    tick();
    checkOutput("ab_vpa", 16'(MB_VPA), 16'd1);
    checkOutput("ab_oe", 16'(DATA_OE), 16'd0);
    repeat (12) tick();
    applyStimulus(1'b0, 2'd2, 8'h10, rd);
    applyStimulus(1'b1, 2'd1, 8'h00, rd);
    checkOutput("ab_latch_hi", 16'(rd), 16'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
